swap_seq: RTL

SWAP_SEQ -- requirements
Module: swap_seq

---
 rtl/swap_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/swap_seq.sv
// Register-swap sequencer: captures two register values, then writes each into the other's slot.
// Optional macro SWAP_SEQ_SELF_SKIP_EN: a swap of a register with itself finishes in the capture cycle.
module swap_seq #(
  parameter int RF_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             swap_req,
  input  logic [RF_AW-1:0] rs_a,
  input  logic [RF_AW-1:0] rs_b,
  input  logic [31:0]      rd_a_data,
  input  logic [31:0]      rd_b_data,
  output logic [31:0]      swap_a,
  output logic [31:0]      swap_b,
  output logic             swap_ctrl,
  output logic [1:0]       wb_sel,
  output logic [RF_AW-1:0] wr_addr,
  output logic             wr_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    WR_B = 2'd2,
    WR_A = 2'd3
  } state_t;

  localparam logic [1:0] WB_NORMAL  = 2'd0;
  localparam logic [1:0] WB_SAVED_A = 2'd2;
  localparam logic [1:0] WB_SAVED_B = 2'd3;

  state_t           state;
  state_t           state_nxt;
  logic [RF_AW-1:0] a_addr;
  logic [RF_AW-1:0] b_addr;
  logic [31:0]      a_data;
  logic [31:0]      b_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the capture registers are reset too, so swap_a/swap_b and the
      // latched addresses read zero after reset rather than stale values.
      state  <= IDLE;
      a_addr <= '0;
      b_addr <= '0;
      a_data <= '0;
      b_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && swap_req) begin
        a_addr <= rs_a;
        b_addr <= rs_b;
        a_data <= rd_a_data;
        b_data <= rd_b_data;
      end
    end
  end

  assign swap_a = a_data;
  assign swap_b = b_data;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    state_nxt = state;
    swap_ctrl = 1'b0;
    wb_sel    = WB_NORMAL;
    wr_addr   = '0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req) state_nxt = CAPT;
      end
      CAPT: begin
        swap_ctrl = 1'b1;
        busy      = 1'b1;
`ifdef SWAP_SEQ_SELF_SKIP_EN
        // Swapping a register with itself is a no-op; finish without writes.
        if (a_addr == b_addr) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WR_B;
        end
`else
        state_nxt = WR_B;
`endif
      end
      WR_B: begin
        wr_en     = 1'b1;
        wr_addr   = a_addr;
        wb_sel    = WB_SAVED_B;
        busy      = 1'b1;
        state_nxt = WR_A;
      end
      WR_A: begin
        wr_en     = 1'b1;
        wr_addr   = b_addr;
        wb_sel    = WB_SAVED_A;
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
